// File: rtl/tia_pkg.sv
// rtl/tia_pkg.sv - shared TIA horizontal timing constants, index-to-LFSR table and LFSR step
package tia_pkg;

   // Final count index of a horizontal line; the line is HSC_LAST_DEFAULT+1 steps long.
   localparam int HSC_LAST_DEFAULT = 56;
   localparam int HSC_STEPS        = 57;

   // Step indices at which each horizontal decode is active.
   localparam int IDX_SHB  = 0;
   localparam int IDX_SHS  = 4;
   localparam int IDX_RHS  = 8;
   localparam int IDX_RCB  = 12;
   localparam int IDX_RHB  = 16;
   localparam int IDX_LRHB = 18;
   localparam int IDX_CNT  = 36;

   localparam logic [5:0] LFSR_START  = 6'h00;
   // All-ones is the XNOR feedback fixed point; it must never be held.
   localparam logic [5:0] LFSR_LOCKUP = 6'h3f;

   // LFSR value held at each step index, starting from 000000.
   localparam logic [5:0] HSC_TABLE [0:HSC_STEPS-1] = '{
      6'h00, 6'h01, 6'h03, 6'h07, 6'h0f, 6'h1f, 6'h3e, 6'h3d,
      6'h3b, 6'h37, 6'h2f, 6'h1e, 6'h3c, 6'h39, 6'h33, 6'h27,
      6'h0e, 6'h1d, 6'h3a, 6'h35, 6'h2b, 6'h16, 6'h2c, 6'h18,
      6'h30, 6'h21, 6'h02, 6'h05, 6'h0b, 6'h17, 6'h2e, 6'h1c,
      6'h38, 6'h31, 6'h23, 6'h06, 6'h0d, 6'h1b, 6'h36, 6'h2d,
      6'h1a, 6'h34, 6'h29, 6'h12, 6'h24, 6'h08, 6'h11, 6'h22,
      6'h04, 6'h09, 6'h13, 6'h26, 6'h0c, 6'h19, 6'h32, 6'h25,
      6'h0a
   };

   // One shift of the 6-bit XNOR LFSR.
   function automatic logic [5:0] lfsr_step(input logic [5:0] q);
      return {q[4:0], ~(q[5] ^ q[4])};
   endfunction

endpackage

// File: rtl/tia_hphase_gen.sv
// rtl/tia_hphase_gen.sv - four-clock horizontal phase generator with non-overlapping enables
module tia_hphase_gen (
   input  logic       clk,
   input  logic       reset_bar,
   output logic [1:0] ph,
   output logic       hphi1,
   output logic       hphi2
);

   // Free-running 2-bit phase count, wrapping 3 -> 0.
   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         ph <= 2'd0;
      end else begin
         ph <= ph + 2'd1;
      end
   end

   assign hphi1 = (ph == 2'd1);
   assign hphi2 = (ph == 2'd3);

endmodule

// File: rtl/tia_horizontal_sync_counter.sv
// rtl/tia_horizontal_sync_counter.sv - LFSR horizontal sync counter with line decodes and RSYNC restart
module tia_horizontal_sync_counter
   import tia_pkg::*;
#(
   parameter int HSC_LAST = HSC_LAST_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_bar,
   input  logic       rsync,
   output logic       hphi1,
   output logic       hphi2,
   output logic       shb,
   output logic       shs,
   output logic       rhs,
   output logic       rcb,
   output logic       rhb,
   output logic       lrhb,
   output logic       cnt,
   output logic       rsynd,
   output logic [5:0] hsc_state
);

   localparam logic [5:0] WRAP_VALUE = HSC_TABLE[HSC_LAST];
   localparam logic [5:0] V_SHB      = HSC_TABLE[IDX_SHB];
   localparam logic [5:0] V_SHS      = HSC_TABLE[IDX_SHS];
   localparam logic [5:0] V_RHS      = HSC_TABLE[IDX_RHS];
   localparam logic [5:0] V_RCB      = HSC_TABLE[IDX_RCB];
   localparam logic [5:0] V_RHB      = HSC_TABLE[IDX_RHB];
   localparam logic [5:0] V_LRHB     = HSC_TABLE[IDX_LRHB];
   localparam logic [5:0] V_CNT      = HSC_TABLE[IDX_CNT];

   logic [1:0] ph;
   logic       step;
   logic       rsync_load;
   logic       restart;
   logic [5:0] lfsr;
   logic [5:0] lfsr_next;
   logic       rsync_pend;

   tia_hphase_gen u_hphase (
      .clk       (clk),
      .reset_bar (reset_bar),
      .ph        (ph),
      .hphi1     (hphi1),
      .hphi2     (hphi2)
   );

   // Next LFSR value: held between steps; a step restarts on rsync, wrap or lockup, else shifts.
   always_comb begin
      step       = (ph == 2'd3);
      rsync_load = rsync | rsync_pend;
      restart    = rsync_load | (lfsr == WRAP_VALUE) | (lfsr == LFSR_LOCKUP);
      lfsr_next  = lfsr;
      if (step) begin
         lfsr_next = restart ? LFSR_START : lfsr_step(lfsr);
      end
   end

   // Counter state, pending rsync and the rsync-taken flag (held for one full step after a forced load).
   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         lfsr       <= LFSR_START;
         rsync_pend <= 1'b0;
         rsynd      <= 1'b0;
      end else begin
         lfsr <= lfsr_next;
         if (step) begin
            rsync_pend <= 1'b0;
            rsynd      <= rsync_load;
         end else if (rsync) begin
            rsync_pend <= 1'b1;
         end
      end
   end

   // Decodes are registered off the incoming LFSR value so they change together with the state.
   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         shb  <= 1'b1;
         shs  <= 1'b0;
         rhs  <= 1'b0;
         rcb  <= 1'b0;
         rhb  <= 1'b0;
         lrhb <= 1'b0;
         cnt  <= 1'b0;
      end else begin
         shb  <= (lfsr_next == V_SHB);
         shs  <= (lfsr_next == V_SHS);
         rhs  <= (lfsr_next == V_RHS);
         rcb  <= (lfsr_next == V_RCB);
         rhb  <= (lfsr_next == V_RHB);
         lrhb <= (lfsr_next == V_LRHB);
         cnt  <= (lfsr_next == V_CNT);
      end
   end

   assign hsc_state = lfsr;

endmodule
